flop_readback: RTL and testbench
================================

FLOP_READBACK -- requirements
Module: flop_readback

Interface
REQ-001 Parameters SHALL be: NFLOPS, default 64, number of fabric flop outputs read back; WORD, default 8, width of each output word.
REQ-002 NFLOPS SHALL be a non-zero multiple of WORD, and WORD SHALL be at least 8; other values are unsupported.
REQ-003 Ports SHALL be:
 - clk  in  1  single clock, rising edge.
 - nreset  in  1  asynchronous, active-low reset.
 - start  in  1  request a snapshot and readback.
 - flop_q  in  NFLOPS  Q outputs of the fabric flops being read back.
 - busy  out  1  high whenever the state is not IDLE.
 - out_valid  out  1  output word available.
 - out_ready  in  1  consumer accepts the word.
 - out_data  out  WORD  readback word.
 - out_last  out  1  marks the final word of the frame.
 - done  out  1  one-cycle pulse at frame end.

Function
REQ-004 The FSM SHALL have states IDLE, CAPTURE, SHIFT, CRC and DONE; the CRC state exists only when the CRC feature is compiled in.
REQ-005 When start=1 in IDLE, the FSM SHALL go to CAPTURE on the next edge; start SHALL be ignored in every other state.
REQ-006 In CAPTURE, flop_q SHALL be registered into a shadow register in exactly one cycle, and the FSM SHALL then go to SHIFT; changes on flop_q after this point SHALL NOT affect the frame.
REQ-007 In SHIFT, out_valid=1 and out_data SHALL be shadow word k, bits [k*WORD +: WORD], starting at k=0 (LSB word first).
REQ-008 A word SHALL transfer only on the clk edge where out_valid and out_ready are both 1; k increments on each transfer.
REQ-009 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; out_valid SHALL NOT drop until the transfer completes.
REQ-010 out_last SHALL be 1 only on the final word of the frame: the last data word without CRC, or the CRC word with CRC.
REQ-011 On transfer of the last data word, the FSM SHALL go to CRC if the feature is compiled in, and to DONE otherwise.
REQ-012 DONE SHALL last exactly one cycle, with done=1 and out_valid=0, and the FSM SHALL then return to IDLE.
REQ-013 A start asserted during DONE SHALL be ignored; a new frame needs start in IDLE.
REQ-014 The word counter SHALL be $clog2(NFLOPS/WORD) bits wide, with a minimum of 1 bit.
REQ-015 The word counter SHALL clear in CAPTURE and SHALL NOT wrap within a frame.
REQ-016 With NFLOPS=WORD, the frame SHALL be exactly one data word, and that word SHALL carry out_last when CRC is disabled.
REQ-017 Minimum latency SHALL be as follows, with out_ready held at 1: start sampled at edge 0, CAPTURE during cycle 1, first out_valid during cycle 2.

Reset
REQ-018 nreset=0 SHALL asynchronously force the FSM to IDLE, the word counter to 0, the shadow register to 0 and the CRC accumulator to 0.
REQ-019 While nreset=0, all outputs SHALL be 0: busy, out_valid, out_data, out_last and done.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no further words or done pulse.
REQ-021 After reset release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-022 The macro FLOP_READBACK_CRC_EN SHALL control the CRC feature.
REQ-023 When FLOP_READBACK_CRC_EN is defined, the block SHALL accumulate CRC-8 over every transferred data word:
 - polynomial x^8+x^2+x+1 (0x07), initial value 0x00, no reflection, no final XOR;
 - each word processed MSB-first, words in transmission order.
REQ-024 With the feature defined, the CRC state SHALL then send one extra word: out_data = {zeros, crc[7:0]}, with out_last=1.
REQ-025 When FLOP_READBACK_CRC_EN is not defined, the CRC logic and the CRC state SHALL be absent, and the frame SHALL be NFLOPS/WORD words.

Verification
REQ-026 Reset: nreset=0 during SHIFT -> all outputs 0 at once; after release, busy=0 until the next start.
REQ-027 NFLOPS=16, WORD=8, flop_q=16'hA55A, start pulse, out_ready=1, no CRC:
 - outputs: out_data 8'h5A then 8'hA5 with out_last=1, then done=1 for one cycle;
 - first out_valid 2 cycles after start.
REQ-028 Backpressure with the same frame: hold out_ready=0 for 5 cycles on word 0 -> out_data stays 8'h5A and out_valid stays 1; word 1 follows only after a handshake.
REQ-029 Snapshot isolation: change flop_q to 16'h0000 the cycle after CAPTURE -> the frame still reads 8'h5A, 8'hA5.
REQ-030 CRC on, NFLOPS=8, WORD=8, flop_q=8'h01 -> out_data 8'h01 with out_last=0, then 8'h07 with out_last=1, then done.
REQ-031 start held high throughout a frame -> no restart before DONE; the next frame begins only after a return to IDLE.

Source files
------------

// File: rtl/flop_readback.sv
// flop_readback: snapshots NFLOPS fabric flop outputs and streams them LSB word first over valid/ready.
// Define FLOP_READBACK_CRC_EN to append a CRC-8 (poly 0x07) word after the data words.
module flop_readback #(
  parameter int NFLOPS = 64,
  parameter int WORD   = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [NFLOPS-1:0] flop_q,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD-1:0]   out_data,
  output logic              out_last,
  output logic              done
);

  localparam int NWORDS = NFLOPS / WORD;
  localparam int CNTW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NWORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
`ifdef FLOP_READBACK_CRC_EN
    CRC,
`endif
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NFLOPS-1:0] shadow_q, shadow_d;
  logic [WORD-1:0]   cur_word;

  assign cur_word = shadow_q[WORD*int'(cnt_q) +: WORD];

`ifdef FLOP_READBACK_CRC_EN
  logic [7:0] crc_q, crc_d;

  // Bit-serial CRC-8 over one word, MSB first.
  function automatic logic [7:0] crc8_word(input logic [7:0] crc_in, input logic [WORD-1:0] dat);
    logic [7:0] c;
    c = crc_in;
    for (int i = WORD - 1; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ dat[i]) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
`ifdef FLOP_READBACK_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
`ifdef FLOP_READBACK_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
`ifdef FLOP_READBACK_CRC_EN
    crc_d     = crc_q;
`endif
    busy      = (state_q != IDLE);
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = CAPTURE;
      end
      CAPTURE: begin
        shadow_d = flop_q;
        cnt_d    = '0;
`ifdef FLOP_READBACK_CRC_EN
        crc_d    = '0;
`endif
        state_d  = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_data  = cur_word;
`ifdef FLOP_READBACK_CRC_EN
        out_last  = 1'b0;
`else
        out_last  = (cnt_q == LAST_IDX);
`endif
        if (out_ready) begin
`ifdef FLOP_READBACK_CRC_EN
          crc_d = crc8_word(crc_q, cur_word);
`endif
          // Counter stops at the last index; leaving SHIFT ends the data phase.
          if (cnt_q == LAST_IDX) begin
`ifdef FLOP_READBACK_CRC_EN
            state_d = CRC;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
`ifdef FLOP_READBACK_CRC_EN
      CRC: begin
        out_valid = 1'b1;
        out_data  = WORD'(crc_q);
        out_last  = 1'b1;
        if (out_ready) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flop_readback.sv
// Scoreboard bench for flop_readback: a 16/8 instance and an 8/8 (single-word) instance.
module tb_flop_readback;

`ifdef FLOP_READBACK_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef struct packed {
    logic       is_done;
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic        clk, nreset, out_ready;
  logic        start0, start1;
  logic [15:0] fq0;
  logic [7:0]  fq1;
  logic        busy0, ov0, ol0, dn0;
  logic        busy1, ov1, ol1, dn1;
  logic [7:0]  od0, od1;

  logic        rdy_rand, rdy_force;
  int          checks, errors;
  exp_t        q0[$];
  exp_t        q1[$];
  bit          stall[2];
  logic [8:0]  prev[2];

  flop_readback #(.NFLOPS(16), .WORD(8)) dut0 (
    .clk(clk), .nreset(nreset), .start(start0), .flop_q(fq0), .busy(busy0),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0), .done(dn0)
  );

  flop_readback #(.NFLOPS(8), .WORD(8)) dut1 (
    .clk(clk), .nreset(nreset), .start(start1), .flop_q(fq1), .busy(busy1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1), .done(dn1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC-8: byte-wise XOR-in, 0x07 polynomial, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  task automatic push_item(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_frame(input int d, input logic [15:0] val);
    int         n;
    logic [7:0] crc;
    exp_t       e;
    n   = (d == 0) ? 2 : 1;
    crc = 8'h00;
    for (int k = 0; k < n; k++) begin
      e.is_done = 1'b0;
      e.data    = 8'(val >> (8 * k));
      e.last    = (k == n - 1) && !CRC_ON;
      crc       = crc8_byte(crc, e.data);
      push_item(d, e);
    end
    if (CRC_ON) begin
      e = '{is_done: 1'b0, last: 1'b1, data: crc};
      push_item(d, e);
    end
    e = '{is_done: 1'b1, last: 1'b0, data: 8'h00};
    push_item(d, e);
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [7:0] dat,
                     input logic l, input logic dn);
    exp_t e;
    bit   have;
    if (!nreset) begin
      stall[d] = 1'b0;
      return;
    end
    if (stall[d]) begin
      check_eq("valid_held", 32'(v), 32'd1);
      check_eq("data_last_held", 32'({dat, l}), 32'(prev[d]));
    end
    stall[d] = v && !r;
    prev[d]  = {dat, l};
    if (dn || (v && r)) begin
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_output dut%0d: got data 0x%0h last %0b done %0b, expected no output",
                 d, dat, l, dn);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check_eq(d == 0 ? "item_dut0" : "item_dut1",
                 32'({dn, v, dn ? 1'b0 : l, dn ? 8'h00 : dat}),
                 32'({e.is_done, !e.is_done, e.last, e.data}));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov0, out_ready, od0, ol0, dn0);
    mon(1, ov1, out_ready, od1, ol1, dn1);
  end

  function automatic logic [1:0] bv(input int d);
    return (d == 0) ? {busy0, ov0} : {busy1, ov1};
  endfunction

  task automatic set_in(input int d, input logic s, input logic [15:0] v);
    if (d == 0) begin start0 = s; fq0 = v; end
    else        begin start1 = s; fq1 = v[7:0]; end
  endtask

  task automatic set_start(input int d, input logic s);
    if (d == 0) start0 = s;
    else        start1 = s;
  endtask

  task automatic run_frame(input int d, input logic [15:0] val, input logic [15:0] after,
                           input bit lat, input bit hold, input int stall_cyc);
    bit seen;
    push_frame(d, val);
    @(posedge clk); #1;
    set_in(d, 1'b1, val);
    @(posedge clk); #1;
    if (!hold) set_start(d, 1'b0);
    if (lat) check_eq("latency_capture", 32'(bv(d)), 32'(2'b10));
    @(posedge clk); #1;
    set_in(d, hold, after);
    if (lat) check_eq("latency_first_valid", 32'(bv(d)), 32'(2'b11));
    repeat (stall_cyc) begin
      check_eq("backpressure_hold", 32'({ov0, od0}), 32'({1'b1, val[7:0]}));
      @(posedge clk); #1;
    end
    if (stall_cyc > 0) rdy_force = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      seen = (d == 0) ? dn0 : dn1;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    set_start(d, 1'b0);
    @(posedge clk); #1;
    check_eq("idle_after_done", 32'(bv(d)), 32'(2'b00));
  endtask

  initial begin
    bit seen;
    checks    = 0;
    errors    = 0;
    nreset    = 1'b0;
    start0    = 1'b0;
    start1    = 1'b0;
    fq0       = 16'h0;
    fq1       = 8'h0;
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;

    #12;
    check_eq("reset_outputs_dut0", 32'({busy0, ov0, od0, ol0, dn0}), 32'd0);
    check_eq("reset_outputs_dut1", 32'({busy1, ov1, od1, ol1, dn1}), 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_after_reset", 32'({bv(0), bv(1)}), 32'd0);

    // Basic frame with latency check; flop_q cleared right after capture.
    run_frame(0, 16'hA55A, 16'h0000, 1'b1, 1'b0, 0);
    // Five cycles of backpressure on word 0.
    rdy_force = 1'b0;
    run_frame(0, 16'hA55A, 16'hFFFF, 1'b0, 1'b0, 5);
    // Single-word frame (CRC gives 0x07 for data 0x01).
    run_frame(1, 16'h0001, 16'h00FF, 1'b1, 1'b0, 0);
    // start held through the whole frame.
    run_frame(0, 16'h3CC3, 16'h1234, 1'b0, 1'b1, 0);

    rdy_rand = 1'b1;
    for (int i = 0; i < 25; i++)
      run_frame(0, 16'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 10; i++)
      run_frame(1, 16'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 0);

    // Reset in the middle of a frame aborts it.
    rdy_rand  = 1'b0;
    rdy_force = 1'b0;
    push_frame(0, 16'hC0DE);
    @(posedge clk); #1;
    set_in(0, 1'b1, 16'hC0DE);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = ov0;
    end
    check_eq("reached_shift", 32'(seen), 32'd1);
    #2;
    nreset = 1'b0;
    #1;
    check_eq("midframe_reset_outputs", 32'({busy0, ov0, od0, ol0, dn0}), 32'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    nreset    = 1'b1;
    rdy_force = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("idle_after_abort", 32'({busy0, ov0, dn0}), 32'd0);
    end

    repeat (3) @(posedge clk);
    check_eq("queue0_drained", 32'(q0.size()), 32'd0);
    check_eq("queue1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
